// File: rtl/insn_decode.sv
// Registered RV32I instruction decoder: slices the fixed fields, builds the
// sign-extended immediate for the instruction's format and flags illegal encodings.
module insn_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] insn,
  output logic [4:0]  opcode,
  output logic [6:0]  funct7,
  output logic [2:0]  funct3,
  output logic        invalid,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [31:0] decode_imm(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    case (w[6:2])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
        r = {{20{w[31]}}, w[31:20]};
      OPC_STORE:
        r = {{20{w[31]}}, w[31:25], w[11:7]};
      OPC_BRANCH:
        r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        r = {w[31:12], 12'b0};
      OPC_JAL:
        r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:
        r = '0;
    endcase
    return r;
  endfunction

  // M-extension and other non-base encodings fall out of the funct checks below.
  function automatic logic is_invalid(input logic [31:0] w);
    logic       bad;
    logic [2:0] f3;
    logic [6:0] f7;
    f3  = w[14:12];
    f7  = w[31:25];
    bad = (w[1:0] != 2'b11);
    case (w[6:2])
      OPC_OP:
        if (!((f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))))
          bad = 1'b1;
      OPC_OP_IMM:
        if (((f3 == 3'b001) && (f7 != F7_ZERO)) ||
            ((f3 == 3'b101) && (f7 != F7_ZERO) && (f7 != F7_ALT)))
          bad = 1'b1;
      OPC_BRANCH:
        if ((f3 == 3'b010) || (f3 == 3'b011)) bad = 1'b1;
      OPC_LOAD:
        if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)) bad = 1'b1;
      OPC_STORE:
        if (f3 >= 3'b011) bad = 1'b1;
      OPC_JALR:
        if (f3 != 3'b000) bad = 1'b1;
      OPC_SYSTEM:
        if (f3 == 3'b100) bad = 1'b1;
      OPC_MISC, OPC_AUIPC, OPC_LUI, OPC_JAL: ;
      default:
        bad = 1'b1;
    endcase
    return bad;
  endfunction

  logic [4:0]  opcode_d, opcode_q;
  logic [6:0]  funct7_d, funct7_q;
  logic [2:0]  funct3_d, funct3_q;
  logic        invalid_d, invalid_q;
  logic [4:0]  rd_d, rd_q;
  logic [4:0]  rs1_d, rs1_q;
  logic [4:0]  rs2_d, rs2_q;
  logic [31:0] imm_d, imm_q;

  always_comb begin
    opcode_d  = insn[6:2];
    funct7_d  = insn[31:25];
    funct3_d  = insn[14:12];
    rd_d      = insn[11:7];
    rs1_d     = insn[19:15];
    rs2_d     = insn[24:20];
    imm_d     = decode_imm(insn);
    invalid_d = is_invalid(insn);
  end

  // Decode register: reset clears everything, en gates capture, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q  <= '0;
      funct7_q  <= '0;
      funct3_q  <= '0;
      invalid_q <= 1'b0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
    end else if (en) begin
      opcode_q  <= opcode_d;
      funct7_q  <= funct7_d;
      funct3_q  <= funct3_d;
      invalid_q <= invalid_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
    end
  end

  assign opcode  = opcode_q;
  assign funct7  = funct7_q;
  assign funct3  = funct3_q;
  assign invalid = invalid_q;
  assign rd      = rd_q;
  assign rs1     = rs1_q;
  assign rs2     = rs2_q;
  assign imm     = imm_q;

endmodule

// File: tb/tb_insn_decode.sv
// Scoreboard bench for insn_decode: a driver pushes the expected register
// contents for every issued cycle and a monitor pops and compares after each edge.
module tb_insn_decode;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [31:0] insn;
  logic [4:0]  opcode, rd, rs1, rs2;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic        invalid;
  logic [31:0] imm;

  always #5 clk = ~clk;

  insn_decode dut (
    .clk(clk), .rst(rst), .en(en), .insn(insn),
    .opcode(opcode), .funct7(funct7), .funct3(funct3), .invalid(invalid),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm)
  );

  typedef struct packed {
    logic [4:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        invalid;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } dec_t;

  dec_t exp_q[$];
  dec_t held;
  int   checks = 0;
  int   errors = 0;

  // Interpret the low w bits of v as a two's-complement number.
  function automatic logic [31:0] sext(input longint v, input int w);
    longint r;
    r = v;
    if ((v >> (w - 1)) & 1) r = v - (longint'(1) << w);
    return r[31:0];
  endfunction

  function automatic bit legal(input logic [31:0] w);
    int f3, f7;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    if (w[1:0] != 2'b11) return 0;
    case (w[6:2])
      5'b01100: return (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      5'b00100: begin
        if (f3 == 1) return f7 == 0;
        if (f3 == 5) return f7 == 0 || f7 == 32;
        return 1;
      end
      5'b11000: return f3 != 2 && f3 != 3;
      5'b00000: return f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5;
      5'b01000: return f3 <= 2;
      5'b11001: return f3 == 0;
      5'b11100: return f3 != 4;
      5'b00011, 5'b00101, 5'b01101, 5'b11011: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic dec_t model(input logic [31:0] w);
    dec_t   d;
    longint off;
    d.opcode  = w[6:2];
    d.funct7  = w[31:25];
    d.funct3  = w[14:12];
    d.rd      = w[11:7];
    d.rs1     = w[19:15];
    d.rs2     = w[24:20];
    d.invalid = !legal(w);
    case (w[6:2])
      5'b00100, 5'b00000, 5'b11001, 5'b11100: d.imm = sext(longint'(w[31:20]), 12);
      5'b01000: d.imm = sext(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
      5'b11000: begin
        off = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
            + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        d.imm = sext(off, 13);
      end
      5'b01101, 5'b00101: d.imm = w & 32'hFFFF_F000;
      5'b11011: begin
        off = longint'(w[31]) * (1 << 20) + longint'(w[19:12]) * (1 << 12)
            + longint'(w[20]) * (1 << 11) + longint'(w[30:21]) * 2;
        d.imm = sext(off, 21);
      end
      default: d.imm = 32'h0;
    endcase
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the decode register updates every edge, so each edge retires one entry.
  initial begin
    dec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("opcode",  32'(opcode),  32'(e.opcode));
        check("funct7",  32'(funct7),  32'(e.funct7));
        check("funct3",  32'(funct3),  32'(e.funct3));
        check("invalid", 32'(invalid), 32'(e.invalid));
        check("rd",      32'(rd),      32'(e.rd));
        check("rs1",     32'(rs1),     32'(e.rs1));
        check("rs2",     32'(rs2),     32'(e.rs2));
        check("imm",     imm,          e.imm);
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [31:0] w);
    rst  = r;
    en   = e;
    insn = w;
    if (r) held = '0;
    else if (e) held = model(w);
    exp_q.push_back(held);
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_word();
    logic [4:0] opcs [12];
    logic [31:0] w;
    opcs = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
             5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100, 5'b10110};
    w = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      w[6:2] = opcs[$urandom_range(0, 11)];
      w[1:0] = 2'b11;
      case ($urandom_range(0, 2))
        0: w[31:25] = 7'b0000000;
        1: w[31:25] = 7'b0100000;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    held = '0;
    step(1'b1, 1'b1, 32'hFFF1_0093);
    step(1'b1, 1'b1, 32'hFFF1_0093);
    step(1'b0, 1'b1, 32'hFFF1_0093);
    step(1'b0, 1'b1, 32'h0053_2423);
    step(1'b0, 1'b1, 32'hFE00_0EE3);
    step(1'b0, 1'b1, 32'h1234_51B7);
    step(1'b0, 1'b1, 32'h0010_00EF);
    step(1'b0, 1'b1, 32'h0000_0000);
    step(1'b0, 1'b1, 32'h0220_8033);
    step(1'b0, 1'b1, 32'h0000_9067);
    step(1'b0, 1'b1, 32'h1234_51B7);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0000_0000);
    step(1'b0, 1'b1, 32'h0000_0000);
    step(1'b0, 1'b1, 32'h1234_51B7);
    step(1'b1, 1'b1, 32'h0010_00EF);
    step(1'b0, 1'b1, 32'h0010_00EF);
    for (int k = 0; k < 600; k++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), rand_word());
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
